// File: rtl/player_anim_fsm.sv
// Player animation sequencer: picks sprite-sheet slots from movement state.
// Ports: clk, reset (async high), frame_rate tick, move_state, facing_right,
// airborne -> sprite_slot, rom_base, mirror, anim_state (all registered).
// Optional macro ANIM_BLINK_EN adds a periodic idle blink frame (slot 8).
package player_anim_pkg;
  typedef enum logic [1:0] {
    MV_IDLE = 2'd0,
    MV_WALK = 2'd1,
    MV_JUMP = 2'd2,
    MV_FALL = 2'd3
  } movement_state;
endpackage

module player_anim_fsm
  import player_anim_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int HEIGHT    = 32,
  parameter int ADDR_W    = 14,
  parameter int HOLD_IDLE = 8,
  parameter int HOLD_WALK = 4,
  parameter int TURN_HOLD = 3
`ifdef ANIM_BLINK_EN
  ,
  parameter int BLINK_PERIOD = 120
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_rate,
  input  movement_state     move_state,
  input  logic              facing_right,
  input  logic              airborne,
  output logic [3:0]        sprite_slot,
  output logic [ADDR_W-1:0] rom_base,
  output logic              mirror,
  output logic [1:0]        anim_state
);

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_WALK = 2'd1,
    A_TURN = 2'd2,
    A_AIR  = 2'd3
  } anim_t;

  localparam int SPR = WIDTH * HEIGHT;
  localparam logic [7:0] HI_LAST = 8'(HOLD_IDLE - 1);
  localparam logic [7:0] HW_LAST = 8'(HOLD_WALK - 1);
  localparam logic [7:0] T_LAST  = 8'(TURN_HOLD - 1);

  anim_t             state, state_nx, tgt;
  logic [1:0]        frame, frame_nx;
  logic [7:0]        hold, hold_nx;
  logic [7:0]        turn, turn_nx;
  logic              mir, mir_nx;
  logic              step;
  logic [3:0]        slot_nx;
  logic [ADDR_W-1:0] rom_nx;
`ifdef ANIM_BLINK_EN
  logic [15:0]       idle_t, idle_t_nx;
  logic [1:0]        blink, blink_nx;
`endif

  assign anim_state = state;
  assign mirror     = mir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= A_IDLE;
      frame       <= '0;
      hold        <= '0;
      turn        <= '0;
      mir         <= 1'b1;
      sprite_slot <= '0;
      rom_base    <= '0;
`ifdef ANIM_BLINK_EN
      idle_t      <= '0;
      blink       <= '0;
`endif
    end else begin
      state       <= state_nx;
      frame       <= frame_nx;
      hold        <= hold_nx;
      turn        <= turn_nx;
      mir         <= mir_nx;
      sprite_slot <= slot_nx;
      rom_base    <= rom_nx;
`ifdef ANIM_BLINK_EN
      idle_t      <= idle_t_nx;
      blink       <= blink_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    frame_nx = frame;
    hold_nx  = hold;
    turn_nx  = turn;
    mir_nx   = mir;
    step     = 1'b0;
    tgt      = (move_state == MV_WALK) ? A_WALK : A_IDLE;
`ifdef ANIM_BLINK_EN
    idle_t_nx = idle_t;
    blink_nx  = blink;
`endif
    if (frame_rate) begin
`ifdef ANIM_BLINK_EN
      // Counter and blink only survive a tick that stays in IDLE.
      idle_t_nx = '0;
      blink_nx  = '0;
`endif
      if (airborne) begin
        state_nx = A_AIR;
        mir_nx   = facing_right;
      end else begin
        unique case (state)
          A_AIR: begin
            state_nx = tgt;
            frame_nx = '0;
            hold_nx  = '0;
            mir_nx   = facing_right;
          end
          A_TURN: begin
            if (turn == T_LAST) begin
              state_nx = tgt;
              frame_nx = '0;
              hold_nx  = '0;
              mir_nx   = facing_right;
            end else begin
              turn_nx = turn + 8'd1;
            end
          end
          default: begin
            if (facing_right != mir) begin
              state_nx = A_TURN;
              turn_nx  = '0;
            end else if (state != tgt) begin
              state_nx = tgt;
              frame_nx = '0;
              hold_nx  = '0;
            end else begin
              step = 1'b1;
`ifdef ANIM_BLINK_EN
              // blink 1/2 = first/second blink tick; frame is frozen.
              if (state == A_IDLE) begin
                if (blink == 2'd1) begin
                  blink_nx = 2'd2;
                  step     = 1'b0;
                end else if (blink == 2'd2) begin
                  idle_t_nx = '0;
                end else if (32'(idle_t) + 32'd1
                             == 32'(BLINK_PERIOD)) begin
                  idle_t_nx = idle_t + 16'd1;
                  blink_nx  = 2'd1;
                  step      = 1'b0;
                end else begin
                  idle_t_nx = idle_t + 16'd1;
                end
              end
`endif
            end
          end
        endcase
        if (step) begin
          if (hold == ((state == A_WALK) ? HW_LAST : HI_LAST)) begin
            hold_nx  = '0;
            frame_nx = (state == A_WALK) ? frame + 2'd1
                                         : {1'b0, ~frame[0]};
          end else begin
            hold_nx = hold + 8'd1;
          end
        end
      end
    end
  end

  // Slot and ROM base come from the next state so they update together.
  always_comb begin
    slot_nx = 4'd0;
    unique case (1'b1)
      state_nx == A_AIR:  slot_nx = 4'd7;
      state_nx == A_TURN: slot_nx = 4'd6;
      state_nx == A_WALK: slot_nx = 4'd2 + {2'b00, frame_nx};
      default:            slot_nx = {2'b00, frame_nx};
    endcase
`ifdef ANIM_BLINK_EN
    if (state_nx == A_IDLE && blink_nx != 2'd0)
      slot_nx = 4'd8;
`endif
    rom_nx = ADDR_W'(32'(slot_nx) * 32'(SPR));
  end

endmodule

// File: tb/tb_player_anim_fsm.sv
// Directed scoreboard bench for player_anim_fsm.
// Expected outputs come from a behavioural model kept in the bench.
module tb_player_anim_fsm;
  import player_anim_pkg::*;

  localparam int W  = 32;
  localparam int H  = 32;
  localparam int AW = 14;
  localparam int HI = 8;
  localparam int HW = 4;
  localparam int TH = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_rate;
  movement_state move_state;
  logic          facing_right;
  logic          airborne;
  logic [3:0]    sprite_slot;
  logic [AW-1:0] rom_base;
  logic          mirror;
  logic [1:0]    anim_state;

  always #5 clk = ~clk;

  player_anim_fsm #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW),
    .HOLD_IDLE(HI), .HOLD_WALK(HW), .TURN_HOLD(TH)
`ifdef ANIM_BLINK_EN
    , .BLINK_PERIOD(4)
`endif
  ) dut (
    .clk(clk), .reset(reset), .frame_rate(frame_rate),
    .move_state(move_state), .facing_right(facing_right),
    .airborne(airborne), .sprite_slot(sprite_slot),
    .rom_base(rom_base), .mirror(mirror),
    .anim_state(anim_state)
  );

  typedef struct packed {
    logic [3:0]    slot;
    logic [AW-1:0] base;
    logic          mir;
    logic [1:0]    st;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // model: st 0 idle,1 walk,2 turn,3 air; left = ticks until frame step
  int m_st, m_fr, m_left, m_tleft;
  bit m_mir;

  function automatic exp_t mk(int s, bit mi, int st);
    exp_t e;
    e.slot = 4'(s);
    e.base = AW'(s * W * H);
    e.mir  = mi;
    e.st   = 2'(st);
    return e;
  endfunction

  function automatic exp_t model_out();
    int s;
    case (m_st)
      0:       s = m_fr;
      1:       s = 2 + m_fr;
      2:       s = 6;
      default: s = 7;
    endcase
    return mk(s, m_mir, m_st);
  endfunction

  task automatic model_reset();
    m_st = 0; m_fr = 0; m_left = HI; m_tleft = 0; m_mir = 1'b1;
  endtask

  task automatic model_step(input movement_state ms,
                            input bit fac, input bit air);
    int want;
    want = (ms == MV_WALK) ? 1 : 0;
    if (air) begin
      m_st = 3;
      m_mir = fac;
    end else if (m_st == 3) begin
      m_st = want; m_fr = 0; m_mir = fac;
      m_left = want ? HW : HI;
    end else if (m_st == 2) begin
      m_tleft--;
      if (m_tleft == 0) begin
        m_st = want; m_fr = 0; m_mir = fac;
        m_left = want ? HW : HI;
      end
    end else if (fac != m_mir) begin
      m_st = 2;
      m_tleft = TH;
    end else if (want != m_st) begin
      m_st = want; m_fr = 0;
      m_left = want ? HW : HI;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_fr = (m_fr + 1) % (m_st == 1 ? 4 : 2);
        m_left = (m_st == 1) ? HW : HI;
      end
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    e = sbq.pop_front();
    chk("slot", int'(sprite_slot), int'(e.slot));
    chk("rom_base", int'(rom_base), int'(e.base));
    chk("mirror", int'(mirror), int'(e.mir));
    chk("anim_state", int'(anim_state), int'(e.st));
  endtask

  task automatic tick_exp(input bit fr, input movement_state ms,
                          input bit fac, input bit air,
                          input exp_t e);
    frame_rate   = fr;
    move_state   = ms;
    facing_right = fac;
    airborne     = air;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic tick(input bit fr, input movement_state ms,
                      input bit fac, input bit air);
    if (fr) model_step(ms, fac, air);
    tick_exp(fr, ms, fac, air, model_out());
  endtask

  initial begin
    reset = 1'b1;
    frame_rate = 1'b0;
    move_state = MV_IDLE;
    facing_right = 1'b1;
    airborne = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    sbq.push_back(mk(0, 1'b1, 0));
    compare_out();
    reset = 1'b0;

`ifdef ANIM_BLINK_EN
    begin
      int bl[6] = '{0, 0, 0, 8, 8, 0};
      for (int i = 0; i < 6; i++)
        tick_exp(1'b1, MV_IDLE, 1'b1, 1'b0, mk(bl[i], 1'b1, 0));
    end
`else
    repeat (20) tick(1'b1, MV_IDLE, 1'b1, 1'b0);
    repeat (17) tick(1'b1, MV_WALK, 1'b1, 1'b0);
    repeat (4)  tick(1'b1, MV_WALK, 1'b0, 1'b0);
    repeat (8)  tick(1'b1, MV_WALK, 1'b0, 1'b0);
    tick(1'b1, MV_WALK, 1'b0, 1'b1);
    tick(1'b1, MV_WALK, 1'b1, 1'b1);
    tick(1'b1, MV_IDLE, 1'b1, 1'b0);
    repeat (3) tick(1'b1, MV_JUMP, 1'b1, 1'b0);
    tick(1'b1, MV_IDLE, 1'b0, 1'b0);
    tick(1'b1, MV_IDLE, 1'b0, 1'b1);
    tick(1'b1, MV_WALK, 1'b0, 1'b0);
    tick(1'b1, MV_WALK, 1'b1, 1'b0);
    repeat (4) tick(1'b1, MV_WALK, 1'b0, 1'b0);
    repeat (100)
      tick(1'b0, movement_state'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom));
    tick(1'b1, MV_IDLE, 1'b1, 1'b0);
    tick(1'b1, MV_IDLE, 1'b1, 1'b0);
    chk("in_turn", int'(anim_state), 2);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    sbq.push_back(mk(0, 1'b1, 0));
    compare_out();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) tick(1'b1, MV_IDLE, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
